mem_bank: RTL and testbench

- Parametrised word-organised memory bank; successor to the fixed 8x8 bit-cell array.
- Generalises word width and depth.
- Adds clocked single-port read/write, a registered read path with a valid strobe, and a hardware clear sequencer with busy indication.
- Sits between the address decoder / control front end and the IC data bus.

---
 rtl/mem_bank.sv | 123 ++++++++++++
 tb/tb_mem_bank.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank.sv
// Word-organised memory bank with registered single-port access, a read-valid
// strobe and a hardware clear sequencer that zeroes every word in DEPTH cycles.
module mem_bank #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sel,
    input  logic              i_rw,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_clear,
    output logic [WIDTH-1:0]  o_rdata,
    output logic              o_rvalid,
    output logic              o_busy,
    output logic              o_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t                        state_reg, state_next;
    logic [ADDR_W-1:0]             cnt_reg, cnt_next;
    logic [DEPTH-1:0][WIDTH-1:0]   words;
    logic [WIDTH-1:0]              rdata_reg;
    logic                          rvalid_reg;
    logic                          err_reg;

    logic addr_ok;
    logic accept;
    logic wr_en;
    logic rd_en;
    logic clr_en;

    // Only non-power-of-two depths can present an address past the last word.
    assign addr_ok = ({1'b0, i_addr} < DEPTH_EXT);
    assign accept  = (state_reg == IDLE) && i_sel && !i_clear && addr_ok;
    assign wr_en   = accept && i_rw;
    assign rd_en   = accept && !i_rw;
    assign clr_en  = (state_reg == CLEAR);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (i_clear) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                if (cnt_reg == LAST_ADDR) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + ADDR_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // One register per word so the whole array can be zeroed by the async reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [WIDTH-1:0] word_reg;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    word_reg <= '0;
                end else if (wr_en && (i_addr == ADDR_W'(gi))) begin
                    word_reg <= i_wdata;
                end else if (clr_en && (cnt_reg == ADDR_W'(gi))) begin
                    word_reg <= '0;
                end
            end

            assign words[gi] = word_reg;
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            rvalid_reg <= rd_en;
            // Any request that is not accepted is flagged, including clear-priority drops.
            err_reg    <= i_sel && ((state_reg != IDLE) || i_clear || !addr_ok);
            if (rd_en) begin
                rdata_reg <= words[i_addr];
            end
        end
    end

    assign o_rdata  = rdata_reg;
    assign o_rvalid = rvalid_reg;
    assign o_err    = err_reg;
    assign o_busy   = (state_reg == CLEAR);

endmodule

// File: tb/tb_mem_bank.sv
// Self-checking bench for mem_bank: table-driven vectors on an 8-deep and a
// 5-deep instance, read data checked through a scoreboard queue.
`timescale 1ns/1ps
module tb_mem_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       sel8, rw8, clr8, sel5, rw5, clr5;
    logic [2:0] addr8, addr5;
    logic [7:0] wd8, wd5;
    logic [7:0] rdata8, rdata5;
    logic       rvalid8, busy8, err8, rvalid5, busy5, err5;

    mem_bank #(.WIDTH(8), .DEPTH(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_sel(sel8), .i_rw(rw8), .i_addr(addr8),
        .i_wdata(wd8), .i_clear(clr8), .o_rdata(rdata8), .o_rvalid(rvalid8),
        .o_busy(busy8), .o_err(err8)
    );

    mem_bank #(.WIDTH(8), .DEPTH(5)) dut5 (
        .i_clk(clk), .i_rst(rst), .i_sel(sel5), .i_rw(rw5), .i_addr(addr5),
        .i_wdata(wd5), .i_clear(clr5), .o_rdata(rdata5), .o_rvalid(rvalid5),
        .o_busy(busy5), .o_err(err5)
    );

    typedef struct {
        bit         d5;
        bit         sel;
        bit         rw;
        logic [2:0] addr;
        logic [7:0] wdata;
        bit         clr;
        bit         exp_err;
        bit         exp_busy;
        bit         exp_rvalid;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];
    logic [7:0] hold[2];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit d5, input bit sel, input bit rw, input logic [2:0] a,
                                input logic [7:0] d, input bit clr, input bit err, input bit busy,
                                input bit rv, input logic [7:0] rd);
        vec_t v;
        v.d5 = d5; v.sel = sel; v.rw = rw; v.addr = a; v.wdata = d; v.clr = clr;
        v.exp_err = err; v.exp_busy = busy; v.exp_rvalid = rv; v.exp_rdata = rd;
        return v;
    endfunction

    function automatic vec_t wr(input bit d5, input logic [2:0] a, input logic [7:0] d,
                                input bit err, input bit busy);
        return mk(d5, 1'b1, 1'b1, a, d, 1'b0, err, busy, 1'b0, 8'h00);
    endfunction

    function automatic vec_t rd(input bit d5, input logic [2:0] a, input logic [7:0] e);
        return mk(d5, 1'b1, 1'b0, a, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, e);
    endfunction

    function automatic vec_t rd_rej(input bit d5, input logic [2:0] a, input bit busy);
        return mk(d5, 1'b1, 1'b0, a, 8'h00, 1'b0, 1'b1, busy, 1'b0, 8'h00);
    endfunction

    function automatic vec_t nop(input bit d5, input bit busy, input bit clr);
        return mk(d5, 1'b0, 1'b0, 3'd0, 8'h00, clr, 1'b0, busy, 1'b0, 8'h00);
    endfunction

    task automatic idle_inputs();
        sel8 = 0; rw8 = 0; addr8 = '0; wd8 = '0; clr8 = 0;
        sel5 = 0; rw5 = 0; addr5 = '0; wd5 = '0; clr5 = 0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic       a_err, a_busy, a_rv;
        logic [7:0] a_rd, e_rd;
        @(negedge clk);
        idle_inputs();
        if (v.d5) begin
            sel5 = v.sel; rw5 = v.rw; addr5 = v.addr; wd5 = v.wdata; clr5 = v.clr;
        end else begin
            sel8 = v.sel; rw8 = v.rw; addr8 = v.addr; wd8 = v.wdata; clr8 = v.clr;
        end
        if (v.exp_rvalid) sb.push_back(v.exp_rdata);
        @(posedge clk);
        #1;
        a_err  = v.d5 ? err5    : err8;
        a_busy = v.d5 ? busy5   : busy8;
        a_rv   = v.d5 ? rvalid5 : rvalid8;
        a_rd   = v.d5 ? rdata5  : rdata8;
        check_bit($sformatf("v%0d_d%0d_err", idx, v.d5 ? 5 : 8), a_err, v.exp_err);
        check_bit($sformatf("v%0d_d%0d_busy", idx, v.d5 ? 5 : 8), a_busy, v.exp_busy);
        check_bit($sformatf("v%0d_d%0d_rvalid", idx, v.d5 ? 5 : 8), a_rv, v.exp_rvalid);
        if (a_rv || v.exp_rvalid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL v%0d_scoreboard: got read data %02h with no expected entry", idx, a_rd);
            end else begin
                e_rd = sb.pop_front();
                if (a_rv) begin
                    check_byte($sformatf("v%0d_d%0d_rdata", idx, v.d5 ? 5 : 8), a_rd, e_rd);
                    hold[v.d5] = e_rd;
                end
            end
        end else begin
            check_byte($sformatf("v%0d_d%0d_rdata_hold", idx, v.d5 ? 5 : 8), a_rd, hold[v.d5]);
        end
        $display("vec %0d dut%0d sel=%b rw=%b addr=%0d wdata=%02h clr=%b -> err=%b busy=%b rvalid=%b rdata=%02h",
                 idx, v.d5 ? 5 : 8, v.sel, v.rw, v.addr, v.wdata, v.clr, a_err, a_busy, a_rv, a_rd);
    endtask

    int vec_idx = 0;

    task automatic run_table();
        foreach (vecs[i]) begin
            apply(vecs[i], vec_idx);
            vec_idx++;
        end
        vecs.delete();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        hold[0] = 8'h00;
        hold[1] = 8'h00;
        #1 rst = 1'b1;
        #2;
        check_byte("reset_rdata8", rdata8, 8'h00);
        check_bit("reset_rvalid8", rvalid8, 1'b0);
        check_bit("reset_busy8", busy8, 1'b0);
        check_bit("reset_err8", err8, 1'b0);
        check_byte("reset_rdata5", rdata5, 8'h00);
        check_bit("reset_busy5", busy5, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Reset contents, write then read-back, neighbour untouched.
        for (int a = 0; a < 8; a++) vecs.push_back(rd(0, 3'(a), 8'h00));
        vecs.push_back(wr(0, 3'd3, 8'hA5, 0, 0));
        vecs.push_back(rd(0, 3'd3, 8'hA5));
        vecs.push_back(rd(0, 3'd2, 8'h00));
        run_table();

        // Fill, clear for exactly 8 busy cycles with rejected accesses and an ignored clear.
        for (int k = 0; k < 8; k++) vecs.push_back(wr(0, 3'(k), 8'(k * 17), 0, 0));
        vecs.push_back(nop(0, 1, 1));
        vecs.push_back(nop(0, 1, 0));
        vecs.push_back(nop(0, 1, 0));
        vecs.push_back(rd_rej(0, 3'd5, 1));
        vecs.push_back(nop(0, 1, 0));
        vecs.push_back(nop(0, 1, 1));
        vecs.push_back(nop(0, 1, 0));
        vecs.push_back(nop(0, 1, 0));
        vecs.push_back(wr(0, 3'd1, 8'hFF, 1, 0));
        for (int a = 0; a < 8; a++) vecs.push_back(rd(0, 3'(a), 8'h00));
        run_table();

        // Non-power-of-two depth: out-of-range accesses rejected, contents intact.
        for (int k = 0; k < 5; k++) vecs.push_back(wr(1, 3'(k), 8'(16 + k), 0, 0));
        vecs.push_back(rd(1, 3'd4, 8'h14));
        vecs.push_back(wr(1, 3'd6, 8'h3C, 1, 0));
        vecs.push_back(rd_rej(1, 3'd6, 0));
        for (int k = 0; k < 5; k++) vecs.push_back(rd(1, 3'(k), 8'(16 + k)));
        run_table();

        // Clear takes priority over a simultaneous write.
        vecs.push_back(wr(0, 3'd0, 8'h42, 0, 0));
        vecs.push_back(mk(0, 1'b1, 1'b1, 3'd0, 8'h77, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00));
        for (int k = 0; k < 7; k++) vecs.push_back(nop(0, 1, 0));
        vecs.push_back(nop(0, 0, 0));
        vecs.push_back(rd(0, 3'd0, 8'h00));
        run_table();

        // Reset in the third clear cycle after filling with 0xFF.
        for (int k = 0; k < 8; k++) vecs.push_back(wr(0, 3'(k), 8'hFF, 0, 0));
        vecs.push_back(nop(0, 1, 1));
        vecs.push_back(nop(0, 1, 0));
        vecs.push_back(nop(0, 1, 0));
        run_table();
        #2;
        rst = 1'b1;
        #1;
        check_bit("midclear_busy_async", busy8, 1'b0);
        check_bit("midclear_err_async", err8, 1'b0);
        check_bit("midclear_rvalid_async", rvalid8, 1'b0);
        check_byte("midclear_rdata_async", rdata8, 8'h00);
        $display("async reset mid-clear: busy=%b rdata=%02h", busy8, rdata8);
        @(negedge clk);
        rst = 1'b0;
        hold[0] = 8'h00;
        hold[1] = 8'h00;
        sb.delete();
        vecs.push_back(nop(0, 0, 0));
        vecs.push_back(nop(0, 0, 0));
        for (int a = 0; a < 8; a++) vecs.push_back(rd(0, 3'(a), 8'h00));
        run_table();

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending reads expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
